sprite_layer_renderer: RTL and testbench

//  Positioned, scaled, animated sprite layer for the VGA pipeline. Takes the raster

---
 rtl/sprite_pkg.sv | 21 ++
 rtl/tank_palette.sv | 35 +++
 rtl/sprite_layer_renderer.sv | 128 ++++++++++++
 tb/tb_sprite_layer_renderer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite layer: colour struct, screen size,
// facing directions and a width helper that never returns zero.
package sprite_pkg;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb4_t;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;

   // Counter width for a modulus of n; a 1-value counter still gets one bit.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tank_palette.sv
// Combinational palette lookup: sprite ROM index -> 4-bit RGB.
// Only the low four index bits select one of the sixteen tank colours.
module tank_palette
   import sprite_pkg::*;
#(
   parameter int IDX_W = 4
) (
   input  logic [IDX_W-1:0] idx,
   output rgb4_t            rgb
);

   always_comb begin
      rgb = '0;
      unique case (idx[3:0])
         4'h0: rgb = {4'h0, 4'h0, 4'h0};
         4'h1: rgb = {4'hF, 4'h0, 4'h0};
         4'h2: rgb = {4'h0, 4'hF, 4'h0};
         4'h3: rgb = {4'h0, 4'h0, 4'hF};
         4'h4: rgb = {4'hF, 4'hF, 4'h0};
         4'h5: rgb = {4'h4, 4'hA, 4'h2};
         4'h6: rgb = {4'h8, 4'h8, 4'h8};
         4'h7: rgb = {4'hF, 4'hF, 4'hF};
         4'h8: rgb = {4'h8, 4'h4, 4'h0};
         4'h9: rgb = {4'h0, 4'hF, 4'hF};
         4'hA: rgb = {4'hF, 4'h0, 4'hF};
         4'hB: rgb = {4'h3, 4'h3, 4'h3};
         4'hC: rgb = {4'hA, 4'h5, 4'h2};
         4'hD: rgb = {4'h2, 4'hA, 4'h5};
         4'hE: rgb = {4'h5, 4'h2, 4'hA};
         4'hF: rgb = {4'hC, 4'hC, 4'hC};
         default: rgb = '0;
      endcase
   end

endmodule

// File: rtl/sprite_layer_renderer.sv
// Positioned, scaled, animated sprite layer: latches sprite state at frame start and
// renders through a 3-stage pipeline (address, ROM read, palette) into RGB + opaque flag.
module sprite_layer_renderer
   import sprite_pkg::*;
#(
   parameter int SPR_W      = 32,
   parameter int SPR_H      = 32,
   parameter int SCALE_LOG2 = 0,
   parameter int N_DIRS     = 4,
   parameter int N_PHASES   = 2,
   parameter int IDX_W      = 4,
   parameter int TRANSP_IDX = 0,
   parameter int ANIM_DIV   = 8,
   localparam int DIR_W     = width_of(N_DIRS),
   localparam int ADDR_W    = $clog2(N_DIRS*N_PHASES*SPR_W*SPR_H)
) (
   input  logic              vga_clk,
   input  logic              reset_n,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              blank,
   input  logic [9:0]        pos_x,
   input  logic [9:0]        pos_y,
   input  logic [DIR_W-1:0]  dir,
   input  logic              moving,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [IDX_W-1:0]  rom_q,
   output logic [3:0]        red,
   output logic [3:0]        green,
   output logic [3:0]        blue,
   output logic              sprite_on
);

   localparam int PH_W  = width_of(N_PHASES);
   localparam int DIV_W = width_of(ANIM_DIV);
   localparam logic [10:0]      BOX_W    = 11'(SPR_W << SCALE_LOG2);
   localparam logic [10:0]      BOX_H    = 11'(SPR_H << SCALE_LOG2);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(N_PHASES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);
   localparam logic [IDX_W-1:0] TRANSP   = IDX_W'(TRANSP_IDX);

   logic [9:0]       pos_x_q, pos_y_q;
   logic [DIR_W-1:0] dir_q;
   logic             moving_q;
   logic [PH_W-1:0]  phase_q;
   logic [DIV_W-1:0] div_q;
   logic             frame_start;

   assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

   // Sprite state is sampled only at frame start so a frame never tears.
   // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         pos_x_q  <= '0;
         pos_y_q  <= '0;
         dir_q    <= '0;
         moving_q <= 1'b0;
         phase_q  <= '0;
         div_q    <= '0;
      end else if (frame_start) begin
         pos_x_q  <= pos_x;
         pos_y_q  <= pos_y;
         dir_q    <= dir;
         moving_q <= moving;
         if (moving_q) begin
            if (div_q == DIV_LAST) begin
               div_q   <= '0;
               phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
            end else begin
               div_q <= div_q + 1'b1;
            end
         end
      end
   end

   // S1 combinational: 11-bit offsets so a sprite near the right/bottom edge clips.
   logic [10:0]       dx, dy;
   logic              inbox;
   logic [31:0]       frame_idx;
   logic [ADDR_W-1:0] addr_s1;

   always_comb begin
      dx        = {1'b0, DrawX} - {1'b0, pos_x_q};
      dy        = {1'b0, DrawY} - {1'b0, pos_y_q};
      inbox     = !dx[10] && !dy[10] && (dx < BOX_W) && (dy < BOX_H);
      frame_idx = 32'(dir_q) * 32'(N_PHASES) + 32'(phase_q);
      addr_s1   = ADDR_W'((frame_idx * 32'(SPR_H) + 32'(dy >> SCALE_LOG2)) * 32'(SPR_W)
                          + 32'(dx >> SCALE_LOG2));
   end

   logic  inbox_d1, blank_d1, inbox_d2, blank_d2;
   logic  opaque;
   rgb4_t pal_rgb, pix_q;

   tank_palette #(.IDX_W(IDX_W)) u_palette (
      .idx (rom_q),
      .rgb (pal_rgb)
   );

   assign opaque = blank_d2 && inbox_d2 && (rom_q != TRANSP);

   // NOTE: every pipeline stage is reset so a mid-line reset leaves no stale pixels behind.
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         rom_address <= '0;
         inbox_d1    <= 1'b0;
         blank_d1    <= 1'b0;
         inbox_d2    <= 1'b0;
         blank_d2    <= 1'b0;
         sprite_on   <= 1'b0;
         pix_q       <= '0;
      end else begin
         rom_address <= inbox ? addr_s1 : '0;
         inbox_d1    <= inbox;
         blank_d1    <= blank;
         inbox_d2    <= inbox_d1;
         blank_d2    <= blank_d1;
         sprite_on   <= opaque;
         pix_q       <= opaque ? pal_rgb : '0;
      end
   end

   assign red   = pix_q.r;
   assign green = pix_q.g;
   assign blue  = pix_q.b;

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Directed bench for sprite_layer_renderer: an unscaled and a 2x-scaled instance share
// the raster stimulus, each with its own registered ROM model.
module tb_sprite_layer_renderer;
   import sprite_pkg::*;

   localparam int ADDR_W = 13;
   localparam logic [11:0] PAL5 = 12'h4A2;

   logic              vga_clk = 1'b0;
   logic              reset_n;
   logic [9:0]        DrawX, DrawY, pos_x, pos_y;
   logic              blank, moving;
   logic [1:0]        dir;
   logic [ADDR_W-1:0] rom_address, rom_address_s;
   logic [3:0]        rom_q, rom_q_s;
   logic [3:0]        red, green, blue, red_s, green_s, blue_s;
   logic              sprite_on, sprite_on_s;
   logic [3:0]        rom_mem [0:8191];

   always #5 vga_clk = ~vga_clk;

   always @(posedge vga_clk) begin
      rom_q   <= rom_mem[rom_address];
      rom_q_s <= rom_mem[rom_address_s];
   end

   sprite_layer_renderer dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .moving(moving),
      .rom_address(rom_address), .rom_q(rom_q),
      .red(red), .green(green), .blue(blue), .sprite_on(sprite_on)
   );

   sprite_layer_renderer #(.SCALE_LOG2(1)) dut_s (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .moving(moving),
      .rom_address(rom_address_s), .rom_q(rom_q_s),
      .red(red_s), .green(green_s), .blue(blue_s), .sprite_on(sprite_on_s)
   );

   typedef struct {
      bit         chk;
      bit         on;
      logic [11:0] rgb;
      int         x;
      int         y;
   } exp_t;

   exp_t expq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   sel_s = 1'b0;

   function automatic logic cur_on();
      return sel_s ? sprite_on_s : sprite_on;
   endfunction

   function automatic logic [11:0] cur_rgb();
      return sel_s ? {red_s, green_s, blue_s} : {red, green, blue};
   endfunction

   // Drive one pixel, clock it, and hand back the expectation for the pixel whose
   // result is now on the outputs (driven two steps earlier).
   task automatic step(input int x, input int y, input bit bl, input bit chk, input bit on,
                       output bit have, output exp_t e);
      exp_t n;
      DrawX = 10'(x);
      DrawY = 10'(y);
      blank = bl;
      n.chk = chk; n.on = on; n.rgb = on ? PAL5 : 12'h000; n.x = x; n.y = y;
      expq.push_back(n);
      @(posedge vga_clk);
      #1;
      have = (expq.size() == 3);
      e    = have ? expq.pop_front() : n;
   endtask

   task automatic test_reset();
      bit have; exp_t e;
      expq.delete();
      sel_s = 0;
      pos_x = 10'd0; pos_y = 10'd0; dir = DIR_RIGHT; moving = 1'b1;
      for (int f = 0; f < 9; f++) begin
         step(0, 0, 0, 0, 0, have, e);
         step(1, 0, 0, 0, 0, have, e);
      end
      step(3, 2, 1, 0, 0, have, e);
      n_cmp++;
      if (rom_address !== 13'd3139) begin
         n_bad++;
         $display("FAIL reset_preamble_addr: rom_address=%0d expected 3139", rom_address);
      end
      step(4, 2, 1, 0, 0, have, e);
      reset_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(5 + i, 2, 1, 0, 0, have, e);
         n_cmp++;
         if (rom_address !== '0 || sprite_on !== 1'b0 || cur_rgb() !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_hold[%0d]: addr=%0d on=%b rgb=%h expected 0/0/000",
                     i, rom_address, sprite_on, cur_rgb());
         end
      end
      reset_n = 1'b1;
      pos_x = 10'd300; pos_y = 10'd300; dir = DIR_LEFT;
      expq.delete();
      step(3, 2, 1, 1, 1, have, e);
      n_cmp++;
      if (rom_address !== 13'd67 || sprite_on !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release_r1: addr=%0d on=%b expected 67/0", rom_address, sprite_on);
      end
      step(4, 2, 1, 1, 1, have, e);
      n_cmp++;
      if (sprite_on !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release_r2: sprite_on=%b expected 0", sprite_on);
      end
      for (int x = 5; x <= 9; x++) begin
         step(x, 2, x <= 7, x <= 7, 1, have, e);
         if (have && e.chk) begin
            n_cmp++;
            if (cur_on() !== e.on || cur_rgb() !== e.rgb) begin
               n_bad++;
               $display("FAIL reset_after (%0d,%0d): on=%b rgb=%h expected on=%b rgb=%h",
                        e.x, e.y, cur_on(), cur_rgb(), e.on, e.rgb);
            end
         end
      end
   endtask

   task automatic test_placement();
      bit have; exp_t e;
      int rows[4] = '{49, 50, 81, 82};
      expq.delete();
      sel_s = 0;
      pos_x = 10'd100; pos_y = 10'd50; dir = DIR_UP; moving = 1'b0;
      step(0, 0, 0, 0, 0, have, e);
      foreach (rows[r]) begin
         for (int x = 98; x <= 135; x++) begin
            step(x, rows[r], x <= 133, x <= 133,
                 (x >= 100 && x <= 131 && rows[r] >= 50 && rows[r] <= 81), have, e);
            if (have && e.chk) begin
               n_cmp++;
               if (cur_on() !== e.on || cur_rgb() !== e.rgb) begin
                  n_bad++;
                  $display("FAIL placement (%0d,%0d): on=%b rgb=%h expected on=%b rgb=%h",
                           e.x, e.y, cur_on(), cur_rgb(), e.on, e.rgb);
               end
            end
         end
      end
      for (int x = 100; x <= 105; x++) begin
         step(x, 60, 0, x <= 103, 0, have, e);
         if (have && e.chk) begin
            n_cmp++;
            if (cur_on() !== 1'b0 || cur_rgb() !== 12'h000) begin
               n_bad++;
               $display("FAIL placement_blank (%0d,%0d): on=%b rgb=%h expected 0/000",
                        e.x, e.y, cur_on(), cur_rgb());
            end
         end
      end
   endtask

   task automatic test_transparency();
      bit have; exp_t e;
      expq.delete();
      sel_s = 0;
      rom_mem[67] = 4'h0;
      pos_x = 10'd0; pos_y = 10'd0;
      step(0, 0, 1, 1, 0, have, e);
      step(1, 0, 1, 1, 1, have, e);
      for (int x = 2; x <= 8; x++) begin
         step(x, 2, x <= 6, x <= 6, (x != 3), have, e);
         if (x == 3) begin
            n_cmp++;
            if (rom_address !== 13'd67) begin
               n_bad++;
               $display("FAIL transp_addr: rom_address=%0d expected 67", rom_address);
            end
         end
         if (have && e.chk) begin
            n_cmp++;
            if (cur_on() !== e.on || cur_rgb() !== e.rgb) begin
               n_bad++;
               $display("FAIL transparency (%0d,%0d): on=%b rgb=%h expected on=%b rgb=%h",
                        e.x, e.y, cur_on(), cur_rgb(), e.on, e.rgb);
            end
         end
      end
      rom_mem[67] = 4'h5;
   endtask

   task automatic test_scale_clip();
      bit have; exp_t e;
      int rows[5] = '{469, 470, 471, 472, 479};
      bit on;
      expq.delete();
      sel_s = 1;
      rom_mem[1] = 4'h0;
      pos_x = 10'd620; pos_y = 10'd470;
      step(0, 0, 0, 0, 0, have, e);
      foreach (rows[r]) begin
         for (int x = 616; x <= 641; x++) begin
            on = (x >= 620 && x <= 639 && rows[r] >= 470 && rows[r] <= 479)
                 && !(rows[r] <= 471 && (x == 622 || x == 623));
            step(x, rows[r], x <= 639, x <= 639, on, have, e);
            if (have && e.chk) begin
               n_cmp++;
               if (cur_on() !== e.on || cur_rgb() !== e.rgb) begin
                  n_bad++;
                  $display("FAIL scale_clip (%0d,%0d): on=%b rgb=%h expected on=%b rgb=%h",
                           e.x, e.y, cur_on(), cur_rgb(), e.on, e.rgb);
               end
            end
         end
      end
      for (int x = 0; x <= 47; x++) begin
         step(x, 470, x <= 45, x <= 45, 0, have, e);
         if (have && e.chk) begin
            n_cmp++;
            if (cur_on() !== 1'b0) begin
               n_bad++;
               $display("FAIL clip_nowrap (%0d,%0d): on=%b expected 0", e.x, e.y, cur_on());
            end
         end
      end
      step(625, 475, 1, 0, 0, have, e);
      n_cmp++;
      if (rom_address_s !== 13'd66) begin
         n_bad++;
         $display("FAIL scale_addr: rom_address=%0d expected 66", rom_address_s);
      end
      rom_mem[1] = 4'h5;
      sel_s = 0;
   endtask

   task automatic test_animation();
      bit have; exp_t e;
      logic [ADDR_W-1:0] want;
      expq.delete();
      sel_s = 0;
      pos_x = 10'd0; pos_y = 10'd0; dir = DIR_DOWN; moving = 1'b1;
      for (int f = 1; f <= 41; f++) begin
         if (f == 26) moving = 1'b0;
         step(0, 0, 0, 0, 0, have, e);
         step(1, 0, 0, 0, 0, have, e);
         want = ((f >= 9 && f <= 16) || f >= 25) ? 13'd5121 : 13'd4097;
         n_cmp++;
         if (rom_address !== want) begin
            n_bad++;
            $display("FAIL animation frame %0d: rom_address=%0d expected %0d", f, rom_address, want);
         end
      end
   endtask

   task automatic test_midframe();
      bit have; exp_t e;
      int xs[2] = '{198, 398};
      expq.delete();
      sel_s = 0;
      pos_x = 10'd200; pos_y = 10'd190; dir = DIR_UP; moving = 1'b0;
      step(0, 0, 0, 0, 0, have, e);
      for (int pass = 0; pass < 3; pass++) begin
         if (pass == 1) pos_x = 10'd400;
         if (pass == 2) step(0, 0, 0, 0, 0, have, e);
         foreach (xs[k]) begin
            for (int x = xs[k]; x <= xs[k] + 7; x++) begin
               step(x, (pass == 0) ? 199 : 200, x <= xs[k] + 5, x <= xs[k] + 5,
                    (pass < 2) ? (x >= 200 && x <= 231) : (x >= 400 && x <= 431), have, e);
               if (have && e.chk) begin
                  n_cmp++;
                  if (cur_on() !== e.on || cur_rgb() !== e.rgb) begin
                     n_bad++;
                     $display("FAIL midframe pass%0d (%0d,%0d): on=%b rgb=%h expected on=%b rgb=%h",
                              pass, e.x, e.y, cur_on(), cur_rgb(), e.on, e.rgb);
                  end
               end
            end
         end
      end
   endtask

   initial begin
      bit have; exp_t e;
      for (int i = 0; i < 8192; i++) rom_mem[i] = 4'h5;
      reset_n = 1'b0;
      pos_x = '0; pos_y = '0; dir = '0; moving = 1'b0;
      for (int i = 0; i < 3; i++) step(10 + i, 10, 0, 0, 0, have, e);
      reset_n = 1'b1;
      test_reset();
      test_placement();
      test_transparency();
      test_scale_clip();
      test_animation();
      test_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
